// File: rtl/binary_to_excess3_seq_pkg.sv
// Shared definitions for the sequential binary-to-Excess-3 encoder:
// FSM encoding, the Excess-3 bias and the decimal range limit.
package binary_to_excess3_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] EX3_BIAS = 4'd3;

    localparam int DEFAULT_DIGITS = 2;

    // Largest value representable in the given number of decimal digits.
    function automatic longint unsigned dec_max(input int digits);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam longint unsigned DEC_MAX = dec_max(DEFAULT_DIGITS);

endpackage

// File: rtl/binary_to_excess3_seq_adj3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj3
    import binary_to_excess3_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + EX3_BIAS : din;

endmodule

// File: rtl/binary_to_excess3_seq.sv
// Sequential binary-to-Excess-3 encoder: shift-and-add-3 over BIN_W cycles,
// then a per-digit +3 bias; result held on a valid/ready output.
module binary_to_excess3_seq
    import binary_to_excess3_seq_pkg::*;
#(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_ex3,
    output logic                  out_err,
    output logic                  busy
);

    localparam int              BCD_W     = 4 * DIGITS;
    localparam int              CNT_W     = $clog2(BIN_W + 1);
    localparam longint unsigned DEC_LIMIT = dec_max(DIGITS);

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   bcd;
    logic [CNT_W-1:0]   cnt;
    logic               err;
    logic [BCD_W-1:0]   ex3_q;
    logic               err_q;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shl;
    logic [BIN_W-1:0]   sh_shl;
    logic [63:0]        bin_ext;
    logic               last_shift;

    // Nibble-wise Excess-3 bias, no carry between digits.
    function automatic logic [BCD_W-1:0] add_bias(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = b[4*i +: 4] + EX3_BIAS;
        end
        return r;
    endfunction

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj3 u_adj (
            .din  (bcd[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    // BCD and binary registers shift as one word, MSB of the binary first.
    assign {bcd_shl, sh_shl} = {bcd_adj, shreg} << 1;
    assign bin_ext    = 64'(in_bin);
    assign last_shift = (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            bcd   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            ex3_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in_bin;
                        bcd   <= '0;
                        cnt   <= CNT_W'(BIN_W);
                        err   <= (bin_ext > DEC_LIMIT);
                    end
                end
                SHIFT: begin
                    shreg <= sh_shl;
                    bcd   <= bcd_shl;
                    cnt   <= cnt - CNT_W'(1);
                    // Out-of-range results read as all-zero, an illegal Ex3 code.
                    if (last_shift) begin
                        ex3_q <= err ? '0 : add_bias(bcd_shl);
                        err_q <= err;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_ex3 = ex3_q;
    assign out_err = err_q;

endmodule

// File: tb/tb_binary_to_excess3_seq.sv
// Directed and randomized checks of binary_to_excess3_seq against a
// decimal-arithmetic reference model.
module tb_binary_to_excess3_seq;

    localparam int BIN_W  = 7;
    localparam int DIGITS = 2;
    localparam int EX3_W  = 4 * DIGITS;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [BIN_W-1:0]   in_bin;
    logic               out_valid;
    logic               out_ready;
    logic [EX3_W-1:0]   out_ex3;
    logic               out_err;
    logic               busy;

    int checks = 0;
    int errors = 0;

    binary_to_excess3_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ex3   (out_ex3),
        .out_err   (out_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits of v, each plus three.
    function automatic logic [EX3_W-1:0] ex3_model(input int v);
        logic [EX3_W-1:0] r;
        int rem;
        r   = '0;
        rem = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((rem % 10) + 3);
            rem = rem / 10;
        end
        return r;
    endfunction

    function automatic int ex3_decode(input logic [EX3_W-1:0] w);
        int val;
        int scale;
        val   = 0;
        scale = 1;
        for (int i = 0; i < DIGITS; i++) begin
            val   = val + (int'(w[4*i +: 4]) - 3) * scale;
            scale = scale * 10;
        end
        return val;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_bin   = BIN_W'(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic run_one(input string tag, input int v,
                           input logic [EX3_W-1:0] exp_ex3, input logic exp_err);
        int lat;
        out_ready = 1'b1;
        send(v);
        wait_valid(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(BIN_W));
        chk({tag, "_ex3"}, 32'(out_ex3), 32'(exp_ex3));
        chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
        chk({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        tick();
        chk({tag, "_out_valid_clr"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int nxt;
        int got;
        int cyc;
        int v;
        int q[$];
        logic acc;
        logic take;
        logic [EX3_W-1:0] ex_s;
        logic er_s;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bin    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ex3",   32'(out_ex3),   32'd0);
        chk("rst_out_err",   32'(out_err),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);

        run_one("v42",  42,  8'b0111_0101, 1'b0);
        run_one("v75",  75,  8'b1010_1000, 1'b0);
        run_one("v0",   0,   8'b0011_0011, 1'b0);
        run_one("v99",  99,  8'b1100_1100, 1'b0);
        run_one("v100", 100, 8'h00,        1'b1);
        run_one("v127", 127, 8'h00,        1'b1);

        // Stall the output and try to sneak in a second request.
        out_ready = 1'b0;
        send(63);
        wait_valid(lat);
        chk("stall_latency", 32'(lat), 32'(BIN_W));
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            in_bin   = BIN_W'(5);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_ex3",       32'(out_ex3),   32'b1001_0110);
            chk("stall_in_ready",  32'(in_ready),  32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_release_valid", 32'(out_valid), 32'd0);
        chk("stall_release_ready", 32'(in_ready),  32'd1);
        tick();
        chk("stall_no_extra_busy",  32'(busy),      32'd0);
        chk("stall_no_extra_valid", 32'(out_valid), 32'd0);

        // Abort mid-conversion.
        send(88);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        run_one("v12", 12, 8'b0100_0101, 1'b0);

        // Back-to-back stream 0..99 with random backpressure.
        nxt = 0;
        got = 0;
        cyc = 0;
        while (got < 100 && cyc < 5000) begin
            in_valid  = (nxt < 100);
            in_bin    = BIN_W'(nxt);
            out_ready = 1'($urandom_range(0, 1));
            acc  = in_valid && in_ready;
            take = out_valid && out_ready;
            ex_s = out_ex3;
            er_s = out_err;
            tick();
            cyc++;
            if (acc) begin
                q.push_back(nxt);
                nxt++;
            end
            if (take) begin
                if (q.size() == 0) begin
                    chk("stream_spurious_output", 32'd1, 32'd0);
                end else begin
                    v = q.pop_front();
                    chk("stream_ex3",    32'(ex_s), 32'(ex3_model(v)));
                    chk("stream_decode", 32'(ex3_decode(ex_s)), 32'(v));
                    chk("stream_err",    32'(er_s), 32'd0);
                    got++;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream_count",   32'(got),      32'd100);
        chk("stream_pending", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
